// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, divide op encoding and divider FSM states.
package alu_pkg;

  // ALU operation codes driven on alu_ctrl
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_OR   = 4'd7;
  localparam logic [3:0] ALU_AND  = 4'd8;

  // RV32M divide flavours, encoded as funct3[1:0]
  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEG_A,
    ST_NEG_B,
    ST_CMP,
    ST_SUB,
    ST_NEG_Q,
    ST_NEG_R,
    ST_DONE
  } div_state_e;

  // DIV and REM treat their operands as two's complement
  function automatic logic div_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/alu_div_seq.sv
// Restoring divider that borrows the shared ALU for every compare, subtract and
// negation. Operands are made positive first, the quotient/remainder signs are
// fixed up at the end.
module alu_div_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [3:0]      alu_ctrl,
  output logic            alu_ext,
  input  logic [XLEN-1:0] alu_out
);

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic            a_neg_q, a_neg_d;     // signed op with negative dividend
  logic            b_neg_q, b_neg_d;     // signed op with negative divisor
  logic [XLEN-1:0] dvd_q, dvd_d;         // dividend magnitude
  logic [XLEN-1:0] dsr_q, dsr_d;         // divisor magnitude
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic            ge_q, ge_d;           // partial remainder >= divisor
  logic [4:0]      cnt_q, cnt_d;         // current quotient bit index

  logic [XLEN-1:0] rem_shift;
  logic            req_signed;

  // State and datapath registers, cleared asynchronously so an abort leaves no trace
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 2'd0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      ge_q    <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      ge_q    <= ge_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rem_shift  = {rem_q[XLEN-2:0], dvd_q[cnt_q]};
  assign req_signed = div_is_signed(req_op);

  // Next-state, ALU issue and handshake outputs
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_neg_d    = a_neg_q;
    b_neg_d    = b_neg_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    ge_d       = ge_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    alu_ctrl   = ALU_ADD;
    alu_src1   = '0;
    alu_src2   = '0;
    alu_ext    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          a_neg_d = req_signed & req_a[XLEN-1];
          b_neg_d = req_signed & req_b[XLEN-1];
          dvd_d   = req_a;
          dsr_d   = req_b;
          cnt_d   = 5'(XLEN - 1);
          ge_d    = 1'b0;
          if (req_b == '0) begin
            quo_d   = ALL_ONES;
            rem_d   = req_a;
            state_d = ST_DONE;
          end else if (req_signed && req_a == MIN_NEG && req_b == ALL_ONES) begin
            quo_d   = MIN_NEG;
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            quo_d   = '0;
            rem_d   = '0;
            state_d = ST_NEG_A;
          end
        end
      end
      ST_NEG_A: begin
        alu_ctrl = ALU_SUB;
        alu_src2 = dvd_q;
        if (a_neg_q) dvd_d = alu_out;
        state_d = ST_NEG_B;
      end
      ST_NEG_B: begin
        alu_ctrl = ALU_SUB;
        alu_src2 = dsr_q;
        if (b_neg_q) dsr_d = alu_out;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        // A bit shifted out of rem means rem' exceeds any 32-bit divisor
        alu_ctrl = ALU_SLTU;
        alu_src1 = rem_shift;
        alu_src2 = dsr_q;
        rem_d    = rem_shift;
        ge_d     = rem_q[XLEN-1] | ~alu_out[0];
        state_d  = ST_SUB;
      end
      ST_SUB: begin
        alu_ctrl = ALU_SUB;
        alu_src1 = rem_q;
        alu_src2 = dsr_q;
        if (ge_q) rem_d = alu_out;
        quo_d[cnt_q] = ge_q;
        if (cnt_q == 5'd0) begin
          state_d = ST_NEG_Q;
        end else begin
          cnt_d   = cnt_q - 5'd1;
          state_d = ST_CMP;
        end
      end
      ST_NEG_Q: begin
        alu_ctrl = ALU_SUB;
        alu_src2 = quo_q;
        if (a_neg_q ^ b_neg_q) quo_d = alu_out;
        state_d = ST_NEG_R;
      end
      ST_NEG_R: begin
        alu_ctrl = ALU_SUB;
        alu_src2 = rem_q;
        if (a_neg_q) rem_d = alu_out;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_data  = op_q[1] ? rem_q : quo_q;
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
